// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC sequencer.
// Covers the FSM state encoding, fault codes and word widths.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_TIMEOUT  = 2'b01,
    FC_MISALIGN = 2'b10
  } fault_code_e;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC select with word-alignment check.
// Priority order: jump, then taken branch, then sequential pc+4.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_confirm,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // NOTE: every output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    next_pc = pc + XLEN'(4);
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_confirm) begin
      next_pc = branch_target;
    end
  end

  assign misaligned = !is_aligned(next_pc);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch/execute sequencer: fetches from imem, strobes execute,
// and steers the PC through jumps and branches; HALTED/FAULT hold until reset.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              IMEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_confirm,
  input  logic [XLEN-1:0]    branch_target,
  input  logic               jump,
  input  logic [XLEN-1:0]    jump_target,
  input  logic               halt,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  output logic [XLEN-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               exec_en,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [XLEN-1:0]    retired
);

  localparam int CNT_W = (IMEM_TIMEOUT < 1) ? 1 : $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IMEM_TIMEOUT);

  seq_state_e         state, state_next;
  logic [XLEN-1:0]    pc_r, pc_next;
  logic [INSTR_W-1:0] instr_r, instr_next;
  logic [XLEN-1:0]    retired_r, retired_next;
  logic               fault_r, fault_next;
  fault_code_e        code_r, code_next;
  logic [CNT_W-1:0]   wait_r, wait_next;

  logic [XLEN-1:0]    target_pc;
  logic               target_misaligned;

  next_pc_mux u_next_pc_mux (
    .pc             (pc_r),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_confirm (branch_confirm),
    .branch_target  (branch_target),
    .next_pc        (target_pc),
    .misaligned     (target_misaligned)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc_r      <= RESET_VECTOR;
      instr_r   <= '0;
      retired_r <= '0;
      fault_r   <= 1'b0;
      code_r    <= FC_NONE;
      wait_r    <= '0;
    end else begin
      state     <= state_next;
      pc_r      <= pc_next;
      instr_r   <= instr_next;
      retired_r <= retired_next;
      fault_r   <= fault_next;
      code_r    <= code_next;
      wait_r    <= wait_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc_r;
    instr_next   = instr_r;
    retired_next = retired_r;
    fault_next   = fault_r;
    code_next    = code_r;
    wait_next    = wait_r;

    unique case (state)
      ST_FETCH: begin
        if (imem_ready) begin
          instr_next = imem_rdata;
          state_next = ST_EXEC;
        end else begin
          wait_next  = '0;
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_ready) begin
          instr_next = imem_rdata;
          state_next = ST_EXEC;
        end else if (wait_r == TIMEOUT_CNT) begin
          fault_next = 1'b1;
          code_next  = FC_TIMEOUT;
          state_next = ST_FAULT;
        end else begin
          wait_next = wait_r + CNT_W'(1);
        end
      end

      ST_EXEC: begin
        // The instruction retires even when its successor PC is rejected.
        retired_next = retired_r + XLEN'(1);
        if (target_misaligned) begin
          fault_next = 1'b1;
          code_next  = FC_MISALIGN;
          state_next = ST_FAULT;
        end else begin
          pc_next    = target_pc;
          state_next = halt ? ST_HALTED : ST_FETCH;
        end
      end

      ST_HALTED, ST_FAULT: begin
      end

      default: begin
        state_next = ST_FAULT;
      end
    endcase
  end

  assign imem_req   = (state == ST_FETCH) || (state == ST_WAIT);
  assign imem_addr  = pc_r;
  assign exec_en    = (state == ST_EXEC);
  assign pc         = pc_r;
  assign instr      = instr_r;
  assign retired    = retired_r;
  assign fault      = fault_r;
  assign fault_code = code_r;

endmodule
